// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key schedule: loads the round-10 key and streams round keys 10..0 over
// valid/ready, rebuilding each earlier key from XOR chains and four shared s_box lookups.

module inv_key_schedule #(
    parameter int NR       = 10,
    parameter int SBOX_TO  = 16,
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {S_IDLE, S_OUT, S_XOR, S_SBOX, S_MIX, S_DONE} state_t;

    localparam int              TO_W    = $clog2(SBOX_TO);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SBOX_TO - 1);

    state_t          state_q, state_d;
    logic [127:0]    rk_q, rk_d;
    logic [3:0]      round_q, round_d;
    logic [95:0]     wk_q, wk_d;      // {w1', w2', w3'} of the key being rebuilt
    logic [31:0]     sub_q, sub_d;
    logic [3:0]      cap_q, cap_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;

    logic        sb_en;
    logic [31:0] rot_word;
    logic [3:0]  sb_done;
    logic [7:0]  sb_out [4];

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign sb_en    = (state_q == S_SBOX);
    assign rot_word = {wk_q[23:0], wk_q[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_sbox
        s_box #(.LAT(SBOX_LAT)) u_sbox (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable   (sb_en),
            .data_in  (rot_word[31-8*k -: 8]),
            .done     (sb_done[k]),
            .data_out (sb_out[k])
        );
    end

    always_comb begin
        // NOTE: every target gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        wk_d    = wk_q;
        sub_d   = sub_q;
        cap_d   = cap_q;
        to_d    = to_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rk_d    = key_in;
                    round_d = 4'(NR);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (rk_ready) state_d = (round_q == 4'd0) ? S_DONE : S_XOR;
            end
            S_XOR: begin
                wk_d    = {rk_q[95:64] ^ rk_q[127:96], rk_q[63:32] ^ rk_q[95:64], rk_q[31:0] ^ rk_q[63:32]};
                to_d    = '0;
                cap_d   = '0;
                state_d = S_SBOX;
            end
            S_SBOX: begin
                // Lookups may finish on different cycles, so each result is latched once.
                for (int k = 0; k < 4; k++) begin
                    if (sb_done[k] && !cap_q[k]) begin
                        cap_d[k]            = 1'b1;
                        sub_d[31-8*k -: 8]  = sb_out[k];
                    end
                end
                if (&(cap_q | sb_done)) begin
                    state_d = S_MIX;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_MIX: begin
                rk_d    = {rk_q[127:96] ^ sub_q ^ {rcon(round_q), 24'h0}, wk_q};
                round_d = round_q - 4'd1;
                cap_d   = '0;
                state_d = S_OUT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rk_q    <= '0;
            round_q <= '0;
            wk_q    <= '0;
            sub_q   <= '0;
            cap_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            wk_q    <= wk_d;
            sub_q   <= sub_d;
            cap_q   <= cap_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign rk_out   = rk_q;
    assign rk_round = round_q;
    assign rk_valid = (state_q == S_OUT);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

endmodule

// AES forward S-box with a fixed lookup latency: done rises after LAT enabled cycles
// and the result is held while enable stays high.
module s_box #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic       done,
    output logic [7:0] data_out
);

    localparam int            CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable) cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign done     = enable && (cnt_q == CNT_LAST);
    assign data_out = SBOX[data_in];

endmodule
